// File: rtl/storage_access_arbiter.sv
// storage_access_arbiter: round-robin, burst-bounded arbiter that owns a shared storage register
module storage_access_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             rvalid0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] store_q,
  output logic             busy
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_last, r_rvalid0, r_rvalid1;
  logic [WIDTH-1:0] r_store, r_rdata;
  logic             w_acc0, w_acc1;
  assign w_acc0 = (r_state == OWN0) && req0;
  assign w_acc1 = (r_state == OWN1) && req1;
  // counter holds at LAST so a late contender is switched in on the owner's next access
  always_comb begin
    w_next = (r_state == OWN0) ? (!req0 ? (req1 ? OWN1 : IDLE) : (req1 && r_cnt == LAST) ? OWN1 : OWN0)
           : (r_state == OWN1) ? (!req1 ? (req0 ? OWN0 : IDLE) : (req0 && r_cnt == LAST) ? OWN0 : OWN1)
           : (req0 && req1)    ? (r_last ? OWN0 : OWN1)
           : req0 ? OWN0 : req1 ? OWN1 : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_store   <= '0;
      r_rdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state) ? '0 : ((w_acc0 || w_acc1) && r_cnt != LAST) ? r_cnt + CW'(1) : r_cnt;
      r_last    <= (w_next == OWN0) ? 1'b0 : (w_next == OWN1) ? 1'b1 : r_last;
      r_store   <= (w_acc0 && we0) ? wdata0 : (w_acc1 && we1) ? wdata1 : r_store;
      r_rdata   <= ((w_acc0 && !we0) || (w_acc1 && !we1)) ? r_store : r_rdata;
      r_rvalid0 <= w_acc0 && !we0;
      r_rvalid1 <= w_acc1 && !we1;
    end
  end
  assign gnt0    = (r_state == OWN0);
  assign gnt1    = (r_state == OWN1);
  assign busy    = (r_state != IDLE);
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = r_rdata;
  assign store_q = r_store;
endmodule

// File: tb/tb_storage_access_arbiter.sv
// tb_storage_access_arbiter: directed vectors with hand-computed expectations
module tb_storage_access_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [7:0] rdata, store_q;
  int         errors = 0, checks = 0;
  storage_access_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .store_q(store_q), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rv0", rvalid0, 0);
    check("rst_rv1", rvalid1, 0);
    check("rst_busy", busy, 0);
    check("rst_store", store_q, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    rst = 1'b0;
    req0 = 1; we0 = 1; wdata0 = 8'h55;
    tick();
    check("single_gnt0", gnt0, 1);
    check("single_busy", busy, 1);
    check("single_nowrite_yet", store_q, 8'h00);
    tick();
    check("single_write", store_q, 8'h55);
    we0 = 0;
    tick();
    check("single_rv0", rvalid0, 1);
    check("single_rdata", rdata, 8'h55);
    check("single_rv1", rvalid1, 0);
    req0 = 0;
    tick();
    check("single_rv0_pulse", rvalid0, 0);
    check("single_idle_gnt0", gnt0, 0);
    check("single_idle_busy", busy, 0);
    rst = 1; tick(); rst = 0;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    tick();
    check("tie1_gnt0", gnt0, 1);
    check("tie1_gnt1", gnt1, 0);
    req0 = 0; req1 = 0;
    tick();
    check("tie_drop_busy", busy, 0);
    req0 = 1; req1 = 1;
    tick();
    check("tie2_gnt0", gnt0, 0);
    check("tie2_gnt1", gnt1, 1);
    req0 = 0; req1 = 0;
    tick();
    check("tie2_drop_busy", busy, 0);
    rst = 1; tick(); rst = 0;
    req0 = 1; we0 = 1; wdata0 = 8'hAA; req1 = 1; we1 = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_gnt0_%0d", i), gnt0, 1);
      check($sformatf("burst_gnt1_%0d", i), gnt1, 0);
      tick();
    end
    check("burst_switch_gnt0", gnt0, 0);
    check("burst_switch_gnt1", gnt1, 1);
    check("burst_store", store_q, 8'hAA);
    req0 = 0;
    tick();
    check("burst_rv1", rvalid1, 1);
    check("burst_rdata", rdata, 8'hAA);
    check("burst_rv0", rvalid0, 0);
    req1 = 0;
    tick();
    check("burst_idle", busy, 0);
    req0 = 1; we0 = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      wdata0 = 8'(i + 1);
      tick();
      check($sformatf("hold_gnt0_%0d", i), gnt0, 1);
      check($sformatf("hold_store_%0d", i), store_q, 32'(i + 1));
    end
    req0 = 0;
    tick();
    check("hold_release", busy, 0);
    req0 = 1; we0 = 1; wdata0 = 8'hAA;
    tick();
    tick();
    req0 = 0;
    tick();
    check("mid_pre_store", store_q, 8'hAA);
    req1 = 1; we1 = 1; wdata1 = 8'hFF;
    tick();
    check("mid_gnt1", gnt1, 1);
    check("mid_store_unchanged", store_q, 8'hAA);
    #2 rst = 1;
    #1;
    check("mid_rst_gnt1", gnt1, 0);
    check("mid_rst_store", store_q, 8'h00);
    check("mid_rst_busy", busy, 0);
    tick();
    check("mid_rst_hold_store", store_q, 8'h00);
    req1 = 0; rst = 0;
    tick();
    check("mid_after_rv1", rvalid1, 0);
    check("mid_after_store", store_q, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/storage_access_arbiter.md
Name: storage_access_arbiter

Overview:
- Shares a single WIDTH-bit storage register between two requesters.
- Each requester issues read or write accesses through a req/gnt handshake.
- Arbitration is round-robin with a bounded burst length, so neither requester can starve the other.
- Sits in front of the 8-bit storage element and owns that register; requesters never drive it directly.

Parameters:
- WIDTH, 8: storage and data bus width.
- MAX_BURST, 4: max consecutive accesses by the current owner while the other requester waits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 access request.
- we0  input  1  requester 0 access type: 1 = write, 0 = read.
- wdata0  input  WIDTH  requester 0 write data.
- gnt0  output  1  requester 0 owns the storage (registered).
- rvalid0  output  1  one-cycle pulse: rdata holds requester 0 read result.
- req1  input  1  requester 1 access request.
- we1  input  1  requester 1 access type.
- wdata1  input  WIDTH  requester 1 write data.
- gnt1  output  1  requester 1 owns the storage (registered).
- rvalid1  output  1  one-cycle pulse for requester 1 read result.
- rdata  output  WIDTH  registered read data, shared by both requesters.
- store_q  output  WIDTH  current storage contents.
- busy  output  1  high when the FSM is not IDLE.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; storage = 0; rdata = 0.
  - gnt0 = gnt1 = rvalid0 = rvalid1 = busy = 0; burst count = 0.
  - last_owner = 1, so requester 0 wins the first tie.
  - Reset asserted mid-access aborts it immediately: no write commits and no rvalid follows.
- FSM states and outputs:
  - States are IDLE, OWN0 and OWN1.
  - gnt0 = (state==OWN0) and gnt1 = (state==OWN1), both registered.
  - busy = (state != IDLE).
- Access rule:
  - An access completes on each rising edge where state==OWNx and reqx==1.
  - Write: storage <= wdatax at that edge.
  - Read: rdata <= storage at that edge; rvalidx = 1 for the following cycle only.
  - Only one requester is granted at a time, so there is no read/write collision. A read issued the cycle after a write returns the new value.
- Handshake:
  - Requester holds req, we and wdata stable until it sees gnt.
  - While granted, it may change we/wdata every cycle; each edge with req high counts as one access.
  - Dropping req ends ownership. The cycle in which gnt is high but req is low performs no access.
- Transitions from IDLE:
  - Neither requesting: stay IDLE.
  - One requesting: go to OWN of that requester.
  - Both requesting: go to OWN of the requester that is not last_owner.
  - Latency from req rising in IDLE to gnt high is exactly 1 cycle.
- Transitions from OWNx:
  - reqx==0: go to OWN of the other requester if it is requesting, else IDLE.
  - reqx==1, other requesting, burst count == MAX_BURST-1 at this access edge: go to OWN of the other requester. This is the MAX_BURST-th access.
  - reqx==1 otherwise: stay in OWNx; uncontended ownership is unlimited.
- Burst counter:
  - Increments on each completed access.
  - Cleared whenever state changes.
  - Saturates; it is only meaningful under contention.
  - Width is clog2(MAX_BURST)+1.
- last_owner is updated on entering OWN0 or OWN1.
- A switch from OWNx to OWNy is direct, with no IDLE bubble. gnt moves in the same cycle: gntx falls and gnty rises together.
- The arbitration decision uses req sampled at the edge; changes in req between edges have no effect.

Test Plan:
- Reset: rst=1 -> gnt0=gnt1=0, rvalid0=rvalid1=0, busy=0, store_q=0x00, rdata=0x00.
- Single requester:
  - req0=1, we0=1, wdata0=0x55 -> gnt0=1 one cycle later, and store_q=0x55 after the next edge.
  - Then we0=0 -> rvalid0=1 for one cycle with rdata=0x55.
- Tie from IDLE:
  - After reset, req0 and req1 rise together -> gnt0 first.
  - Both drop, then rise together again -> gnt1 granted.
- Contention burst (MAX_BURST=4):
  - req0 held writing 0xAA, req1 requesting a read -> exactly 4 edges with gnt0.
  - Then gnt0=0 and gnt1=1 in the same cycle.
  - req1's read gives rvalid1=1 with rdata=0xAA.
- Uncontended hold: req0 held for 10 cycles, req1=0 -> gnt0 stays high throughout, 10 accesses, no switch.
- Reset mid-operation:
  - Set storage to 0xAA, then gnt1 with we1=1, wdata1=0xFF.
  - Assert rst between edges -> gnt1=0 immediately, store_q=0x00, no rvalid; storage never reaches 0xFF.
